// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial unsigned subtractor computing a - b - bin, one bit
//               per clock LSB first through a single full subtractor. Result
//               and borrow-out are presented with a one-cycle done pulse.
//               Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_shift;
    logic             w_finish;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             w_d;
    logic             w_br_next;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during SHIFT, so keep a copy.
    logic             r_sa;
    logic             r_sb;
`endif

    // Full subtractor on the current LSBs and the running borrow.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    assign busy = (r_state == S_SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting, and result publication on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= w_finish;
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_br  <= bin;
                r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                r_sa  <= a[WIDTH-1];
                r_sb  <= b[WIDTH-1];
`endif
            end
            if (w_shift) begin
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_finish) begin
                diff <= r_res;
                bout <= r_br;
`ifdef SERIAL_SUB_OVF_EN
                // Signed overflow: operand signs differ and result sign
                // disagrees with the minuend.
                ovf  <= (r_sa ^ r_sb) & (r_res[WIDTH-1] ^ r_sa);
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
module tb_serial_sub;

    localparam int WIDTH = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             bin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble the inputs after acceptance, and wait
    // (bounded) for done. lat = edges after the accepting edge.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                          input logic tbin, output int lat, output int bcnt,
                          output bit moved);
        logic [WIDTH-1:0] held;
        a = ta; b = tb2; bin = tbin; start = 1'b1;
        step();
        start = 1'b0;
        a = ~ta; b = ~tb2; bin = ~tbin;
        held = diff; lat = 0; bcnt = 0; moved = 1'b0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            if (diff !== held) moved = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({busy, done, diff, bout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%0d bout=%b, expected all 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        bit moved;
        run_op(4'd5, 4'd3, 1'b0, lat, bcnt, moved);
        n_tests++;
        if (lat !== WIDTH + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, WIDTH + 1);
        end
        n_tests++;
        if (bcnt !== WIDTH) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, WIDTH);
        end
        n_tests++;
        if (moved) begin
            n_fail++;
            $display("FAIL basic_diff_stable: diff changed during SHIFT, expected held");
        end
        n_tests++;
        if (diff !== 4'd2 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%0d bout=%b expected diff=2 bout=0", diff, bout);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: got done=%b expected 0 one cycle later", done);
        end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va   [5] = '{4'd3, 4'd0, 4'd15, 4'd8, 4'd6};
        logic [WIDTH-1:0] vb   [5] = '{4'd5, 4'd0, 4'd15, 4'd1, 4'd2};
        logic             vbi  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [WIDTH-1:0] vd   [5] = '{4'd14, 4'd15, 4'd0, 4'd7, 4'd4};
        logic             vbo  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic             vov  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bcnt;
        bit moved;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vbi[i], lat, bcnt, moved);
            n_tests++;
            if (lat !== WIDTH + 1 || diff !== vd[i] || bout !== vbo[i] || moved) begin
                n_fail++;
                $display("FAIL vector_%0d: got lat=%0d diff=%0d bout=%b moved=%b expected lat=5 diff=%0d bout=%b moved=0",
                         i, lat, diff, bout, moved, vd[i], vbo[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_tests++;
            if (ovf !== vov[i]) begin
                n_fail++;
                $display("FAIL vector_%0d_ovf: got %b expected %b", i, ovf, vov[i]);
            end
`else
            if (vov[i] === 1'bx) $display("note: unexpected table entry %0d", i);
`endif
            step();
        end
    endtask

    task automatic test_ignore_start();
        int nd = 0;
        logic [WIDTH-1:0] got = '0;
        logic gotb = 1'b1;
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0; a = 4'd1; b = 4'd2;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                nd++;
                got = diff;
                gotb = bout;
            end
            step();
        end
        n_tests++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", nd);
        end
        n_tests++;
        if (got !== 4'd5 || gotb !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got diff=%0d bout=%b expected diff=5 bout=0", got, gotb);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int lat, bcnt;
        bit moved;
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, diff, bout} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b diff=%0d bout=%b expected all 0",
                     busy, done, diff, bout);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (done) nd++;
            step();
        end
        n_tests++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d done pulses expected 0", nd);
        end
        run_op(4'd7, 4'd7, 1'b0, lat, bcnt, moved);
        n_tests++;
        if (lat !== WIDTH + 1 || diff !== 4'd0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart: got lat=%0d diff=%0d bout=%b expected lat=5 diff=0 bout=0",
                     lat, diff, bout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int t [3] = '{0, 0, 0};
        int nd = 0;
        int extra = 0;
        a = 4'd6; b = 4'd2; bin = 1'b0; start = 1'b1;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            step();
            if (done) begin
                t[nd] = c;
                n_tests++;
                if (diff !== 4'd4) begin
                    n_fail++;
                    $display("FAIL b2b_diff_%0d: got %0d expected 4", nd, diff);
                end
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        n_tests++;
        if (nd !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", nd);
        end
        n_tests++;
        if (t[1] - t[0] !== WIDTH + 2 || t[2] - t[1] !== WIDTH + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d and %0d expected 6 and 6", t[1] - t[0], t[2] - t[1]);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d extra done pulses expected 0", extra);
        end
    endtask

    // Stimulus sequence.
    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
